// File: rtl/fb_bus_pkg.sv
// Shared framebuffer bus definitions: command codes, burst length decode and
// target-side state encoding, used by memory targets and the video initiator.
package fb_bus_pkg;

  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned CMD_BITS  = 3;
  localparam int unsigned LEN_BITS  = 2;
  localparam int unsigned TGT_BITS  = 4;
  localparam int unsigned CNT_BITS  = 3;

  typedef enum logic [CMD_BITS-1:0] {
    CMD_IDLE  = 3'b000,
    CMD_READ  = 3'b001,
    CMD_WRITE = 3'b010,
    CMD_RDATA = 3'b100
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACK    = 2'd1,
    ST_RBURST = 2'd2,
    ST_WBURST = 2'd3
  } tgt_state_e;

  // Burst length code to beat count: 0->1, 1->2, 2->4, 3->8.
  function automatic logic [3:0] len_to_beats(input logic [LEN_BITS-1:0] len);
    return 4'd1 << len;
  endfunction

endpackage

// File: rtl/fb_mem_ram.sv
// Single-port synchronous RAM, one-cycle read latency, no reset on contents.
module fb_mem_ram
  import fb_bus_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/fb_mem_target.sv
// Framebuffer memory target: accepts READ/WRITE bursts addressed to TARGET_ID
// and serves them from a local RAM with gapless read beats.
module fb_mem_target
  import fb_bus_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter logic [3:0]  TARGET_ID = 4'd1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reqin,
  input  logic [TGT_BITS-1:0]  reqtarin,
  input  logic [CMD_BITS-1:0]  cmdin,
  input  logic [LEN_BITS-1:0]  lenin,
  input  logic [DATA_BITS-1:0] addrdatain,
  input  logic                 selin,
  output logic                 ackout,
  output logic                 selout,
  output logic [CMD_BITS-1:0]  cmdout,
  output logic [DATA_BITS-1:0] addrdataout,
  output logic                 busy
);

  tgt_state_e            state_q, state_n;
  logic [CMD_BITS-1:0]   cmd_q, cmd_n;
  logic [CNT_BITS-1:0]   cnt_q, cnt_n;
  logic [ADDR_BITS-1:0]  addr_q, addr_n;
  logic [ADDR_BITS-1:0]  req_word_c;
  logic [ADDR_BITS-1:0]  ram_addr_c;
  logic                  ram_we_c;
  logic [DATA_BITS-1:0]  ram_rdata;
  logic                  ack_n, sel_n, busy_n;
  logic [CMD_BITS-1:0]   cmdo_n;
  logic [DATA_BITS-1:0]  data_n;

  assign req_word_c = addrdatain[ADDR_BITS+1:2];

  fb_mem_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .wdata (addrdatain),
    .rdata (ram_rdata)
  );

  // addr_q always holds the next RAM word to touch; for reads the RAM runs one
  // word ahead so each beat's data is already in ram_rdata when it is launched.
  always_comb begin
    state_n    = state_q;
    cmd_n      = cmd_q;
    cnt_n      = cnt_q;
    addr_n     = addr_q;
    ram_addr_c = addr_q;
    ram_we_c   = 1'b0;
    ack_n      = 1'b0;
    sel_n      = 1'b0;
    cmdo_n     = CMD_IDLE;
    data_n     = '0;

    case (state_q)
      ST_IDLE: begin
        ram_addr_c = req_word_c;
        if (reqin && (reqtarin == TARGET_ID)) begin
          state_n = ST_ACK;
          ack_n   = 1'b1;
          cmd_n   = cmdin;
          cnt_n   = CNT_BITS'(len_to_beats(lenin) - 4'd1);
          addr_n  = (cmdin == CMD_READ) ? req_word_c + ADDR_BITS'(1) : req_word_c;
        end
      end

      ST_ACK: begin
        if (cmd_q == CMD_READ) begin
          state_n = ST_RBURST;
          sel_n   = 1'b1;
          cmdo_n  = CMD_RDATA;
          data_n  = ram_rdata;
          addr_n  = addr_q + ADDR_BITS'(1);
        end else if (cmd_q == CMD_WRITE) begin
          state_n = ST_WBURST;
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_RBURST: begin
        if (cnt_q == '0) begin
          state_n = ST_IDLE;
        end else begin
          sel_n  = 1'b1;
          cmdo_n = CMD_RDATA;
          data_n = ram_rdata;
          cnt_n  = cnt_q - CNT_BITS'(1);
          addr_n = addr_q + ADDR_BITS'(1);
        end
      end

      ST_WBURST: begin
        if (selin) begin
          ram_we_c = ~reset;
          addr_n   = addr_q + ADDR_BITS'(1);
          if (cnt_q == '0) begin
            state_n = ST_IDLE;
          end else begin
            cnt_n = cnt_q - CNT_BITS'(1);
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      ackout      <= 1'b0;
      selout      <= 1'b0;
      cmdout      <= CMD_IDLE;
      addrdataout <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      cmd_q       <= cmd_n;
      cnt_q       <= cnt_n;
      addr_q      <= addr_n;
      ackout      <= ack_n;
      selout      <= sel_n;
      cmdout      <= cmdo_n;
      addrdataout <= data_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: doc/fb_mem_target.md
FB_MEM_TARGET -- requirements
Module: fb_mem_target

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, word-address width; memory depth is 2**ADDR_BITS 32-bit words.
REQ-002 SHALL have parameter TARGET_ID, default 4'd1, target number this block answers to.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port reqin  input  1  initiator request valid.
REQ-006 SHALL have port reqtarin  input  4  target number addressed by the request.
REQ-007 SHALL have port cmdin  input  3  request command: 3'b001 READ, 3'b010 WRITE; all other codes are invalid.
REQ-008 SHALL have port lenin  input  2  burst length code: 0->1, 1->2, 2->4, 3->8 beats.
REQ-009 SHALL have port addrdatain  input  32  byte address in the request cycle, write data during write beats.
REQ-010 SHALL have port selin  input  1  write data beat valid.
REQ-011 SHALL have port ackout  output  1  one-cycle request acceptance.
REQ-012 SHALL have port selout  output  1  read data beat valid.
REQ-013 SHALL have port cmdout  output  3  3'b100 RDATA while selout=1, else 3'b000.
REQ-014 SHALL have port addrdataout  output  32  read data; 0 when selout=0.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, ACK, RBURST, WBURST.
REQ-017 IDLE: a request is accepted when reqin=1 and reqtarin==TARGET_ID; reqin=1 with a non-matching reqtarin SHALL be ignored with no ackout.
REQ-018 On an accepted request, the block SHALL latch cmdin, the beat count and the word address addrdatain[ADDR_BITS+1:2], ignoring addrdatain[1:0] and the upper bits.
REQ-019 For an accepted request sampled at edge T, ackout SHALL be 1 for exactly the cycle after T (state ACK).
REQ-020 READ: the first beat SHALL have selout=1 in the cycle after ACK; the remaining beats SHALL follow on consecutive cycles, with no gaps and no stall input.
REQ-021 Each beat SHALL increment the word address by 1 modulo 2**ADDR_BITS, wrapping from the top word to word 0 inside a burst.
REQ-022 WRITE: after ACK the block SHALL be in WBURST and write addrdatain to the current address on each cycle with selin=1.
REQ-023 WBURST SHALL hold with no write on cycles with selin=0, with no timeout.
REQ-024 The last read beat or the last write beat SHALL return the block to IDLE on the next edge.
REQ-025 A new request MAY be accepted in the first IDLE cycle after a burst, giving back-to-back operation.
REQ-026 An invalid cmdin SHALL still be acknowledged and then return to IDLE with no memory access and no selout.
REQ-027 reqin, reqtarin, cmdin and lenin SHALL be ignored outside IDLE.
REQ-028 selin SHALL be ignored outside WBURST.
REQ-029 A read that follows a completed write SHALL return the written data, with no stale read.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While reset=1 at a clock edge: state IDLE; ackout, selout, busy = 0; cmdout = 3'b000; addrdataout = 0; beat counter and address register = 0.
REQ-032 Reset asserted mid-burst SHALL abort the burst with no further beats or writes.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 Reset SHALL take priority over a request in the same cycle.

Structure
REQ-035 Package fb_bus_pkg SHALL hold: cmd enum (IDLE/READ/WRITE/RDATA), len-code-to-beats function, target state enum.
REQ-036 The package SHALL be shared with the video initiator.
REQ-037 Sub-module fb_mem_ram SHALL be a single-port synchronous RAM, 32 x 2**ADDR_BITS, one-cycle read latency, write-enable, no reset.
REQ-038 The top level SHALL prefetch the RAM read during ACK so that REQ-020 timing holds.

Verification
REQ-039 Write, 4 beats, then read, 4 beats: write lenin=2, addr 0x40, data 0xA0..0xA3 with selin continuous; then read lenin=2, addr 0x40 -> ackout 1 cycle, then 4 consecutive selout beats 0xA0,0xA1,0xA2,0xA3 with cmdout=3'b100.
REQ-040 Wrap-around: read lenin=3 at word address 1020 (addr 0xFF0) -> beats come from words 1020..1023, 0..3 in order.
REQ-041 Target mismatch and invalid command: reqtarin=4'd2 -> no ackout and busy stays 0; cmdin=3'b111 -> ackout pulse, no selout, memory unchanged.
REQ-042 Write stall: write lenin=1 with selin pattern 1,0,0,1 -> exactly 2 words written, and busy drops the cycle after the 2nd selin.
REQ-043 Reset mid-read: reset during beat 2 of an 8-beat read -> next cycle selout=0 and all outputs 0; a later read returns the pre-reset memory contents.
REQ-044 Back-to-back: reqin held high with two READ lenin=0 requests -> second ackout occurs 3 cycles after the first.
